// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control slice: datapath geometry and the
// control FSM state encoding.
package fifo_pkg;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      FLUSH = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Control FSM for the 16-entry FIFO datapath: arbitrates push/pop onto the
// single-port RAM, drives all pointer/RAM strobes and tracks full/empty/count.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W_P = ADDR_W,
   parameter int DEPTH_P  = DEPTH
) (
   input  logic              ck,
   input  logic              reset,
   input  logic              push,
   output logic              push_ack,
   input  logic              pop,
   output logic              pop_ack,
   output logic              pop_valid,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W_P:0] count,
   input  logic              test,
   output logic              inc_wp,
   output logic              inc_rp,
   output logic              clear_wp,
   output logic              clear_rp,
   output logic              wp_rp_sel,
   output logic              chip_sel,
   output logic              write_enable,
   output state_t            state_dbg
);

   // Handshake: push/pop are level requests held until the matching ack;
   // the RAM operation and the ack happen in the same cycle, and the request
   // may be dropped or advanced at the clock edge that ends the ack cycle.

   localparam logic [ADDR_W_P:0] ONE = {{ADDR_W_P{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W_P:0]   count_q, count_d;
   logic                wr_last_q, wr_last_d;
   logic                rr_q, rr_d;
   logic                pop_valid_q;

   assign empty     = test & ~wr_last_q;
   assign full      = test & wr_last_q;
   assign count     = count_q;
   assign pop_valid = pop_valid_q;
   assign state_dbg = state_q;

   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         wr_last_q   <= 1'b0;
         rr_q        <= 1'b0;
         pop_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wr_last_q   <= wr_last_d;
         rr_q        <= rr_d;
         pop_valid_q <= (state_q == READ);
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      wr_last_d    = wr_last_q;
      rr_d         = rr_q;
      push_ack     = 1'b0;
      pop_ack      = 1'b0;
      inc_wp       = 1'b0;
      inc_rp       = 1'b0;
      clear_wp     = 1'b0;
      clear_rp     = 1'b0;
      wp_rp_sel    = 1'b0;
      chip_sel     = 1'b0;
      write_enable = 1'b0;
      unique case (state_q)
         IDLE: begin
            // rr=1 means the last grant was a write, so a contended cycle reads
            if (flush)                                  state_d = FLUSH;
            else if (push && !full && pop && !empty)    state_d = rr_q ? READ : WRITE;
            else if (push && !full)                     state_d = WRITE;
            else if (pop && !empty)                     state_d = READ;
         end
         WRITE: begin
            chip_sel     = 1'b1;
            write_enable = 1'b1;
            wp_rp_sel    = 1'b1;
            inc_wp       = 1'b1;
            push_ack     = 1'b1;
            count_d      = count_q + ONE;
            wr_last_d    = 1'b1;
            rr_d         = 1'b1;
            state_d      = IDLE;
         end
         READ: begin
            chip_sel  = 1'b1;
            inc_rp    = 1'b1;
            pop_ack   = 1'b1;
            count_d   = count_q - ONE;
            wr_last_d = 1'b0;
            rr_d      = 1'b0;
            state_d   = IDLE;
         end
         FLUSH: begin
            clear_wp  = 1'b1;
            clear_rp  = 1'b1;
            count_d   = '0;
            wr_last_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
